// File: rtl/hires_pkg.sv
// Shared constants, state encoding and command bounds check for the hi-res port-cycle master.
package hires_pkg;

  localparam logic [8:0] HIRES_PORT_X    = 9'h080;
  localparam logic [8:0] HIRES_PORT_Y    = 9'h081;
  localparam logic [8:0] HIRES_PORT_DATA = 9'h082;
  localparam logic [8:0] HIRES_PORT_OPT  = 9'h083;

  localparam logic [7:0] OPT_FILL = 8'hBC;
  localparam logic [7:0] OPT_READ = 8'hEC;

  // Each non-idle state names the port cycle currently on the bus
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPT,
    ST_SETX,
    ST_SETY,
    ST_DATA,
    ST_DONE
  } hires_state_t;

  // Sums are widened by one bit so 79+80 or 239+240 cannot wrap into range
  function automatic logic cmd_in_bounds(input logic [6:0] x, input logic [7:0] y,
                                         input logic [6:0] w, input logic [7:0] h);
    logic [7:0] x_end;
    logic [8:0] y_end;
    x_end = {1'b0, x} + {1'b0, w};
    y_end = {1'b0, y} + {1'b0, h};
    return (w != 7'd0) && (h != 8'd0) && (x_end <= 8'd80) && (y_end <= 9'd240);
  endfunction

endpackage

// File: rtl/hires_bus_cycle.sv
// Single Z80-style port cycle sequencer: owns strobe, io_access and read-sample timing.
module hires_bus_cycle #(
  parameter int BUS_CYCLES = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic [8:0] addr,
  input  logic [7:0] data,
  input  logic       is_read,
  input  logic [7:0] hires_dout,
  input  logic       hires_dout_rdy,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       timeout,
  output logic [8:0] TRS_A,
  output logic [7:0] TRS_D,
  output logic       TRS_OUT,
  output logic       TRS_IN,
  output logic       io_access
);

  localparam int CNT_MAX = (RD_TIMEOUT > BUS_CYCLES) ? RD_TIMEOUT : BUS_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] cnt;
  logic          got;
  logic          rd_cycle;
  logic          rdy_seen;

  assign rdy_seen = got || hires_dout_rdy;

  // busy covers only the strobe-low clocks, so a start offered during the
  // following idle clock launches the next cycle with exactly one gap clock
  always_ff @(posedge clk) begin
    if (srst) begin
      busy      <= 1'b0;
      cnt       <= '0;
      got       <= 1'b0;
      rd_cycle  <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      timeout   <= 1'b0;
      TRS_A     <= 9'h000;
      TRS_D     <= 8'h00;
      TRS_OUT   <= 1'b1;
      TRS_IN    <= 1'b1;
      io_access <= 1'b0;
    end else begin
      io_access <= 1'b0;
      rd_valid  <= 1'b0;
      timeout   <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy      <= 1'b1;
          cnt       <= '0;
          got       <= 1'b0;
          rd_cycle  <= is_read;
          TRS_A     <= addr;
          TRS_D     <= data;
          TRS_OUT   <= is_read;
          TRS_IN    <= !is_read;
          io_access <= 1'b1;
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (!rd_cycle) begin
          if (cnt == CW'(BUS_CYCLES - 1)) begin
            busy    <= 1'b0;
            TRS_OUT <= 1'b1;
          end
        end else begin
          if (!got && hires_dout_rdy) begin
            got      <= 1'b1;
            rd_data  <= hires_dout;
            rd_valid <= 1'b1;
          end
          if (rdy_seen && (cnt >= CW'(BUS_CYCLES - 1))) begin
            busy   <= 1'b0;
            TRS_IN <= 1'b1;
          end else if (!rdy_seen && (cnt == CW'(RD_TIMEOUT - 1))) begin
            busy    <= 1'b0;
            TRS_IN  <= 1'b1;
            timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hires_fill_master.sv
// Rectangle fill / read-compare command engine driving hi-res board ports 0x80-0x83.
// Build macro HIRES_READBACK_EN enables read-and-compare; without it every command is a fill.
module hires_fill_master #(
  parameter int BUS_CYCLES = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [6:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [7:0]  cmd_pattern,
  input  logic        cmd_read,
  input  logic        cmd_graphics,
  output logic [8:0]  TRS_A,
  output logic [7:0]  TRS_D,
  output logic        TRS_OUT,
  output logic        TRS_IN,
  output logic        io_access,
  input  logic [7:0]  hires_dout,
  input  logic        hires_dout_rdy,
  output logic        done,
  output logic        cmd_err,
  output logic [15:0] mismatch_cnt
);

  import hires_pkg::*;

  hires_state_t state;
  logic [6:0]   x_q, w_q, col;
  logic [7:0]   y_q, h_q, pat_q, row;
  logic         read_q;
  logic         read_mode_cmd;
  logic         cmd_legal, accept, more_rows;
  logic         bc_start, bc_read, bc_busy;
  logic [8:0]   bc_addr;
  logic [7:0]   bc_data, bc_dout, bc_rd_data;
  logic         bc_rdy, bc_rd_valid, bc_timeout, bc_trs_in;

  assign cmd_legal = cmd_in_bounds(cmd_x, cmd_y, cmd_w, cmd_h);
  assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign more_rows = ({1'b0, row} + 9'd1) < {1'b0, h_q};

  // Next port cycle to launch; offered while the previous cycle sits in its idle clock
  always_comb begin
    bc_start = 1'b0;
    bc_addr  = HIRES_PORT_OPT;
    bc_data  = 8'h00;
    bc_read  = 1'b0;
    case (state)
      ST_IDLE: begin
        bc_start = cmd_valid && cmd_ready && cmd_legal;
        bc_data  = (read_mode_cmd ? OPT_READ : OPT_FILL) | {7'b0, cmd_graphics};
      end
      ST_OPT: begin
        bc_start = !bc_busy;
        bc_addr  = HIRES_PORT_X;
        bc_data  = {1'b0, x_q};
      end
      ST_SETX: begin
        bc_start = !bc_busy;
        bc_addr  = HIRES_PORT_Y;
        bc_data  = y_q + row;
      end
      ST_SETY: begin
        bc_start = !bc_busy;
        bc_addr  = HIRES_PORT_DATA;
        bc_data  = read_q ? 8'h00 : pat_q;
        bc_read  = read_q;
      end
      ST_DATA: begin
        if (col < w_q) begin
          bc_start = !bc_busy;
          bc_addr  = HIRES_PORT_DATA;
          bc_data  = read_q ? 8'h00 : pat_q;
          bc_read  = read_q;
        end else if (more_rows) begin
          bc_start = !bc_busy;
          bc_addr  = HIRES_PORT_X;
          bc_data  = {1'b0, x_q};
        end
      end
      default: ;
    endcase
  end

  // X is rewritten at the start of every row rather than trusting auto-increment
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      x_q       <= 7'd0;
      w_q       <= 7'd0;
      y_q       <= 8'd0;
      h_q       <= 8'd0;
      pat_q     <= 8'd0;
      read_q    <= 1'b0;
      row       <= 8'd0;
      col       <= 7'd0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            if (cmd_legal) begin
              x_q    <= cmd_x;
              w_q    <= cmd_w;
              y_q    <= cmd_y;
              h_q    <= cmd_h;
              pat_q  <= cmd_pattern;
              read_q <= read_mode_cmd;
              row    <= 8'd0;
              col    <= 7'd0;
              state  <= ST_OPT;
            end else begin
              cmd_err <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_OPT:  if (!bc_busy) state <= ST_SETX;
        ST_SETX: if (!bc_busy) state <= ST_SETY;
        ST_SETY: begin
          if (!bc_busy) begin
            col   <= 7'd1;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!bc_busy) begin
            if (col < w_q) begin
              col <= col + 7'd1;
            end else if (more_rows) begin
              row   <= row + 8'd1;
              state <= ST_SETX;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hires_bus_cycle #(
    .BUS_CYCLES(BUS_CYCLES),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) u_bus_cycle (
    .clk            (clk),
    .srst           (srst),
    .start          (bc_start),
    .addr           (bc_addr),
    .data           (bc_data),
    .is_read        (bc_read),
    .hires_dout     (bc_dout),
    .hires_dout_rdy (bc_rdy),
    .busy           (bc_busy),
    .rd_data        (bc_rd_data),
    .rd_valid       (bc_rd_valid),
    .timeout        (bc_timeout),
    .TRS_A          (TRS_A),
    .TRS_D          (TRS_D),
    .TRS_OUT        (TRS_OUT),
    .TRS_IN         (bc_trs_in),
    .io_access      (io_access)
  );

`ifdef HIRES_READBACK_EN
  logic [15:0] mismatch_q;
  logic        miss;

  assign read_mode_cmd = cmd_read;
  assign bc_dout       = hires_dout;
  assign bc_rdy        = hires_dout_rdy;
  assign TRS_IN        = bc_trs_in;
  assign mismatch_cnt  = mismatch_q;
  assign miss          = (bc_rd_valid && (bc_rd_data != pat_q)) || bc_timeout;

  // Wrong data and missing data both count; the counter sticks at all-ones
  always_ff @(posedge clk) begin
    if (srst) begin
      mismatch_q <= 16'h0000;
    end else if (accept && cmd_legal) begin
      mismatch_q <= 16'h0000;
    end else if (miss && (mismatch_q != 16'hFFFF)) begin
      mismatch_q <= mismatch_q + 16'd1;
    end
  end
`else
  logic unused_readback;

  assign read_mode_cmd   = 1'b0;
  assign bc_dout         = 8'h00;
  assign bc_rdy          = 1'b0;
  assign TRS_IN          = 1'b1;
  assign mismatch_cnt    = 16'h0000;
  assign unused_readback = ^{cmd_read, hires_dout, hires_dout_rdy,
                             bc_rd_data, bc_rd_valid, bc_timeout, bc_trs_in};
`endif

endmodule

// File: tb/tb_hires_fill_master.sv
// Randomized and directed bench for hires_fill_master against a rectangle-level reference model.
module tb_hires_fill_master;

  localparam int BUS_CYCLES = 4;
  localparam int RD_TIMEOUT = 15;
`ifdef HIRES_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srst;
  logic        cmd_valid, cmd_ready;
  logic [6:0]  cmd_x, cmd_w;
  logic [7:0]  cmd_y, cmd_h, cmd_pattern;
  logic        cmd_read, cmd_graphics;
  logic [8:0]  TRS_A;
  logic [7:0]  TRS_D;
  logic        TRS_OUT, TRS_IN, io_access;
  logic [7:0]  hires_dout;
  logic        hires_dout_rdy;
  logic        done, cmd_err;
  logic [15:0] mismatch_cnt;

  typedef struct {
    int addr;
    int data;
    bit rd;
  } port_cycle_t;

  port_cycle_t obs_q[$];
  port_cycle_t exp_q[$];
  int          board_val[$];
  bit          board_hold[$];
  int          rd_idx = 0;
  int          check_count = 0;
  int          pass_count = 0;
  int          both_low = 0;
  int          idle_access = 0;
  int          bad_len = 0;
  int          trs_in_low = 0;

  hires_fill_master #(
    .BUS_CYCLES(BUS_CYCLES),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk            (clk),
    .srst           (srst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_pattern    (cmd_pattern),
    .cmd_read       (cmd_read),
    .cmd_graphics   (cmd_graphics),
    .TRS_A          (TRS_A),
    .TRS_D          (TRS_D),
    .TRS_OUT        (TRS_OUT),
    .TRS_IN         (TRS_IN),
    .io_access      (io_access),
    .hires_dout     (hires_dout),
    .hires_dout_rdy (hires_dout_rdy),
    .done           (done),
    .cmd_err        (cmd_err),
    .mismatch_cnt   (mismatch_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, observed, observed, expected, expected);
  endtask

  // Bus monitor: records every cycle start and watches strobe hygiene
  initial begin
    int out_run;
    out_run = 0;
    forever begin
      @(negedge clk);
      if (!TRS_OUT && !TRS_IN) both_low++;
      if (io_access && TRS_OUT && TRS_IN) idle_access++;
      if (!TRS_IN) trs_in_low++;
      if (!TRS_OUT) out_run++;
      else begin
        if (out_run != 0 && out_run != BUS_CYCLES) bad_len++;
        out_run = 0;
      end
      if (io_access) obs_q.push_back('{addr: int'(TRS_A), data: int'(TRS_D), rd: !TRS_IN});
    end
  end

  // Board model: answers each read immediately unless told to withhold rdy
  initial begin
    hires_dout = 8'h00;
    hires_dout_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!TRS_IN) begin
        if (io_access) begin
          if (rd_idx < board_val.size() && !board_hold[rd_idx]) begin
            hires_dout = 8'(board_val[rd_idx]);
            hires_dout_rdy = 1'b1;
          end
          rd_idx++;
        end
      end else begin
        hires_dout_rdy = 1'b0;
        hires_dout = 8'h00;
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input int pat, input bit rd, input bit g);
    bit legal, eff_rd, hold;
    int exp_clocks, exp_mm, reads, seen_done, seen_err, in_low0, bv;
    legal  = (w >= 1) && (h >= 1) && (x + w <= 80) && (y + h <= 240);
    eff_rd = rd && READBACK;
    exp_q.delete();
    exp_clocks = 0;
    exp_mm = 0;
    reads = 0;
    if (legal) begin
      exp_q.push_back('{addr: 'h83, data: (eff_rd ? 'hEC : 'hBC) | int'(g), rd: 1'b0});
      exp_clocks = BUS_CYCLES + 1;
      for (int r = 0; r < h; r++) begin
        exp_q.push_back('{addr: 'h80, data: x, rd: 1'b0});
        exp_q.push_back('{addr: 'h81, data: y + r, rd: 1'b0});
        exp_clocks += 2 * (BUS_CYCLES + 1);
        for (int c = 0; c < w; c++) begin
          exp_q.push_back('{addr: 'h82, data: eff_rd ? 0 : pat, rd: eff_rd});
          if (eff_rd) begin
            hold = (reads < board_hold.size()) ? board_hold[reads] : 1'b1;
            bv   = (reads < board_val.size()) ? board_val[reads] : 0;
            if (hold || bv != pat) exp_mm++;
            exp_clocks += (hold ? RD_TIMEOUT : BUS_CYCLES) + 1;
            reads++;
          end else begin
            exp_clocks += BUS_CYCLES + 1;
          end
        end
      end
    end

    @(negedge clk);
    checkOutput("ready_before", cmd_ready, 1);
    obs_q.delete();
    rd_idx = 0;
    in_low0 = trs_in_low;
    cmd_x = 7'(x); cmd_y = 8'(y); cmd_w = 7'(w); cmd_h = 8'(h);
    cmd_pattern = 8'(pat); cmd_read = rd; cmd_graphics = g;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen_done = -1;
    seen_err = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("ready_drop", cmd_ready, 0);
      if (done && seen_done < 0) begin
        seen_done = k;
        checkOutput("mismatch_at_done", mismatch_cnt, exp_mm);
      end
      if (cmd_err && seen_err < 0) seen_err = k;
      if (cmd_ready) break;
    end
    checkOutput("ready_return", cmd_ready, 1);
    checkOutput("done_clock", seen_done, legal ? exp_clocks : -1);
    checkOutput("err_clock", seen_err, legal ? -1 : 0);
    checkOutput("cycle_count", obs_q.size(), exp_q.size());
    checkOutput("trs_in_used", int'(trs_in_low != in_low0), int'(eff_rd));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checkOutput($sformatf("addr[%0d]", i), obs_q[i].addr, exp_q[i].addr);
      checkOutput($sformatf("rd[%0d]", i), int'(obs_q[i].rd), int'(exp_q[i].rd));
      if (!exp_q[i].rd) checkOutput($sformatf("data[%0d]", i), obs_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    int x, y, w, h, dones;
    srst = 1'b1;
    cmd_valid = 1'b0;
    cmd_x = 0; cmd_y = 0; cmd_w = 0; cmd_h = 0;
    cmd_pattern = 0; cmd_read = 0; cmd_graphics = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_TRS_A", TRS_A, 0);
    checkOutput("rst_TRS_D", TRS_D, 0);
    checkOutput("rst_TRS_OUT", TRS_OUT, 1);
    checkOutput("rst_TRS_IN", TRS_IN, 1);
    checkOutput("rst_io_access", io_access, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cmd_err", cmd_err, 0);
    checkOutput("rst_mismatch", mismatch_cnt, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    srst = 1'b0;

    $display("[TB] directed fill and bounds");
    board_val.delete(); board_hold.delete();
    applyStimulus(10, 20, 2, 2, 'h55, 1'b0, 1'b1);
    applyStimulus(79, 239, 1, 1, 'h3C, 1'b0, 1'b0);
    applyStimulus(79, 0, 2, 1, 'h11, 1'b0, 1'b0);
    applyStimulus(5, 5, 0, 1, 'h11, 1'b0, 1'b0);
    applyStimulus(5, 5, 1, 0, 'h11, 1'b0, 1'b0);
    applyStimulus(0, 239, 1, 2, 'h11, 1'b0, 1'b0);

    $display("[TB] directed reads");
    board_val = '{'hAA, 'h00, 'hAA};
    board_hold = '{1'b0, 1'b0, 1'b0};
    applyStimulus(0, 0, 3, 1, 'hAA, 1'b1, 1'b0);
    board_val = '{'hAA, 'hAA, 'hAA};
    board_hold = '{1'b0, 1'b1, 1'b0};
    applyStimulus(0, 0, 3, 1, 'hAA, 1'b1, 1'b0);

    $display("[TB] randomized commands");
    for (int n = 0; n < 12; n++) begin
      x = $urandom_range(0, 79);
      y = $urandom_range(0, 239);
      w = $urandom_range(1, (80 - x) < 5 ? (80 - x) : 5);
      h = $urandom_range(1, (240 - y) < 3 ? (240 - y) : 3);
      board_val.delete(); board_hold.delete();
      for (int i = 0; i < w * h; i++) begin
        board_val.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 'h5A);
        board_hold.push_back($urandom_range(0, 9) == 0);
      end
      applyStimulus(x, y, w, h, 'h5A, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during second data cycle");
    @(negedge clk);
    cmd_x = 0; cmd_y = 0; cmd_w = 4; cmd_h = 1;
    cmd_pattern = 8'h33; cmd_read = 1'b0; cmd_graphics = 1'b0;
    obs_q.delete();
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (obs_q.size() >= 5) break;
    end
    checkOutput("pre_reset_cycles", obs_q.size(), 5);
    srst = 1'b1;
    @(negedge clk);
    checkOutput("srst_TRS_OUT", TRS_OUT, 1);
    checkOutput("srst_TRS_IN", TRS_IN, 1);
    checkOutput("srst_io_access", io_access, 0);
    checkOutput("srst_cmd_ready", cmd_ready, 1);
    srst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("srst_no_done", dones, 0);
    bad_len = 0;
    board_val.delete(); board_hold.delete();
    applyStimulus(3, 7, 3, 2, 'hC3, 1'b0, 1'b1);

    checkOutput("strobes_both_low", both_low, 0);
    checkOutput("io_access_in_idle", idle_access, 0);
    checkOutput("write_strobe_len", bad_len, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/hires_fill_master.md
# hires_fill_master

Port-I/O initiator for the hi-res graphics board. It turns one rectangle command (fill, or optionally read-and-compare) into the Z80-style port cycle sequence the board decodes on ports 0x80–0x83. It drives TRS_A/TRS_D/TRS_OUT/TRS_IN/io_access into the board's port inputs, for self-test, splash drawing and bench stimulus. Runs in the `clk` domain, alongside the hires responder.

## Interface
Parameters:
- BUS_CYCLES, 4: clocks a port cycle's address, data and strobe are held; minimum 4, which covers the responder's 3-stage trigger.
- RD_TIMEOUT, 15: clocks to wait for hires_dout_rdy before declaring a read timeout.

Ports:
- clk  in  1  system clock
- srst  in  1  reset: synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_x  in  7  start byte column, 0–79
- cmd_y  in  8  start line, 0–239
- cmd_w  in  7  width in bytes, 1–80
- cmd_h  in  8  height in lines, 1–240
- cmd_pattern  in  8  fill byte / expected byte
- cmd_read  in  1  1 = read-and-compare, 0 = fill
- cmd_graphics  in  1  value written to option bit0
- TRS_A  out  9  port address
- TRS_D  out  8  port write data
- TRS_OUT  out  1  write strobe, active-low
- TRS_IN  out  1  read strobe, active-low
- io_access  out  1  one-clock qualifier at cycle start
- hires_dout  in  8  board read data
- hires_dout_rdy  in  1  board read data valid
- done  out  1  one-clock pulse, command finished
- cmd_err  out  1  one-clock pulse, command rejected
- mismatch_cnt  out  16  read mismatches plus timeouts for the last command, saturating

## Operation
- Accept a command only in IDLE.
  - Reject it if w==0, h==0, x+w>80 or y+h>240. Compute the bounds at 8 and 9 bits so there is no wrap.
  - On reject: pulse cmd_err, issue no bus cycles, return to IDLE.
- Clear mismatch_cnt on accept.
- State sequence:
  - IDLE → OPT: write port 0x83.
    - Fill: 0xBC|cmd_graphics (auto-increment X on write).
    - Read: 0xEC|cmd_graphics (auto-increment X on read).
  - OPT → SETX: write 0x80 = cmd_x.
  - SETX → SETY: write 0x81 = cmd_y+row.
  - SETY → DATA: cmd_w cycles on port 0x82.
    - Fill: OUT cmd_pattern.
    - Read: IN, with a compare.
  - DATA → SETX if row+1<cmd_h, else → DONE.
  - DONE: pulse done, → IDLE.
- X is rewritten on every row; the board's X auto-increment is never relied on across rows.
- Total port cycles per command: 1 + cmd_h×(2+cmd_w).
- Read compare:
  - Sample hires_dout on the first clock hires_dout_rdy is high within the cycle.
  - Increment mismatch_cnt if the sample ≠ cmd_pattern.
  - If rdy is absent for RD_TIMEOUT clocks, increment mismatch_cnt and end the cycle.
  - mismatch_cnt saturates at 0xFFFF.
- srst mid-command: on the next edge return to IDLE, release strobes, zero outputs. No completion pulse.

## Timing
- Reset values:
  - TRS_A=0, TRS_D=0
  - TRS_OUT=1, TRS_IN=1
  - io_access=0, done=0, cmd_err=0, mismatch_cnt=0
  - cmd_ready=1
- Port write cycle:
  - Clock 0: TRS_A, TRS_D and TRS_OUT=0 are set, and io_access=1 for that one clock.
  - They are held for BUS_CYCLES clocks in total.
  - Then 1 idle clock with strobes high. Per write: BUS_CYCLES+1 clocks.
- Port read cycle:
  - TRS_IN=0 from clock 0, with io_access on clock 0.
  - Held until rdy is sampled or RD_TIMEOUT expires, and for at least BUS_CYCLES clocks.
  - Then 1 idle clock.
- TRS_OUT and TRS_IN are never low together. io_access never occurs in the idle clock.
- cmd_ready drops the clock after accept and returns the clock after done/cmd_err.
- done and cmd_err are registered and pulse for one clock.

## Configuration
- HIRES_READBACK_EN defined: cmd_read, hires_dout, hires_dout_rdy, RD_TIMEOUT and the compare logic are active.
- HIRES_READBACK_EN undefined:
  - cmd_read is ignored, and every command is a fill.
  - TRS_IN is tied to 1 and mismatch_cnt is tied to 0.
  - The read inputs are unused.

## Structure
- Shared package hires_pkg holds:
  - port constants HIRES_PORT_X=9'h80, HIRES_PORT_Y=9'h81, HIRES_PORT_DATA=9'h82, HIRES_PORT_OPT=9'h83
  - option constants OPT_FILL=8'hBC, OPT_READ=8'hEC
  - the state enum
- One sub-module, hires_bus_cycle: a single-cycle sequencer.
  - Inputs: start, addr, data, is_read.
  - Outputs: busy, rd_data, rd_valid, timeout.
  - It owns all strobe and io_access timing.
- The top holds the command FSM and the row/column counters.

## Test plan
- Fill x=10,y=20,w=2,h=2,pattern=0x55,graphics=1 → 9 port cycles:
  - 83←BD
  - 80←0A, 81←14, 82←55, 82←55
  - 80←0A, 81←15, 82←55, 82←55
  - done at clock 45 after accept (BUS_CYCLES=4).
- Bounds: x=79,w=1,y=239,h=1 accepted, 4 cycles. x=79,w=2 → cmd_err pulse, zero io_access. w=0 → cmd_err.
- Read x=0,y=0,w=3,h=1,pattern=0xAA, with the board model returning AA,00,AA → 83←EC, mismatch_cnt=1 at done.
- Board model withholds rdy on the second read → timeout after 15 clocks, mismatch_cnt=1, remaining cycles proceed.
- srst asserted during the second data cycle of a fill → next clock: strobes high, io_access=0, cmd_ready=1, no done. A new command then runs cleanly.
- Build without HIRES_READBACK_EN, cmd_read=1 → fill sequence with 83←BC, TRS_IN constantly 1.
